// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: occupancy encodings and
// default widths, also used by the decode and hazard units.
package wb_port_arbiter_pkg;

  localparam int REG_W_DEF   = 3;
  localparam int DATA_W_DEF  = 16;
  localparam int DEPTH_FIXED = 2;

  // FSM state is the deferred-buffer occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

endpackage : wb_port_arbiter_pkg

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline writeback stage, the late-return (load) path,
// the hazard query and the register-file write port.
interface wb_port_arbiter_if #(
  parameter int REG_W  = wb_port_arbiter_pkg::REG_W_DEF,
  parameter int DATA_W = wb_port_arbiter_pkg::DATA_W_DEF
);

  logic              wb_valid;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_W-1:0]  ld_reg;
  logic [DATA_W-1:0] ld_data;
  logic [REG_W-1:0]  q_reg;
  logic              q_hit;
  logic              rf_we;
  logic [REG_W-1:0]  rf_reg;
  logic [DATA_W-1:0] rf_data;
  logic              err;

  modport master (
    output wb_valid, wb_reg, wb_data, ld_valid, ld_reg, ld_data, q_reg,
    input  ld_ready, q_hit, rf_we, rf_reg, rf_data, err
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, ld_valid, ld_reg, ld_data, q_reg,
    output ld_ready, q_hit, rf_we, rf_reg, rf_data, err
  );

endinterface : wb_port_arbiter_if

// File: rtl/wb_defer_fifo.sv
// Two-entry deferred-write FIFO with per-entry live bits; a pipeline write to
// the same register kills a buffered entry, and q_hit reports live matches.
module wb_defer_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_FIXED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq_i,
  input  logic [REG_W-1:0]  enq_reg_i,
  input  logic [DATA_W-1:0] enq_data_i,
  input  logic              deq_i,
  input  logic              kill_i,
  input  logic [REG_W-1:0]  kill_reg_i,
  input  logic [REG_W-1:0]  q_reg_i,
  output logic              head_live_o,
  output logic [REG_W-1:0]  head_reg_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              q_hit_o
);

  logic [REG_W-1:0]  reg_q  [DEPTH];
  logic [REG_W-1:0]  reg_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              q_hit_s;

  // Kill first, then dequeue, then enqueue, so a fresh tail entry is live
  always_comb begin
    live_d   = live_q;
    reg_d    = reg_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && (reg_q[i] == kill_reg_i)) begin
        live_d[i] = 1'b0;
      end else begin
        live_d[i] = live_d[i];
      end
    end
    if (deq_i) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (enq_i) begin
      live_d[wr_ptr_q] = 1'b1;
      reg_d[wr_ptr_q]  = enq_reg_i;
      data_d[wr_ptr_q] = enq_data_i;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  always_comb begin
    q_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (reg_q[i] == q_reg_i)) begin
        q_hit_s = 1'b1;
      end else begin
        q_hit_s = q_hit_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
    end
  end

  assign head_live_o = live_q[rd_ptr_q];
  assign head_reg_o  = reg_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign q_hit_o     = q_hit_s;

endmodule : wb_defer_fifo

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback wins, deferred late
// returns drain in order, and an idle port lets a late return bypass the buffer.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_FIXED
) (
  input logic             clk,
  input logic             rst_n,
  wb_port_arbiter_if.slave bus
);

  occ_e              state_q, state_d;
  logic              rdy_en_q;
  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_reg_q, rf_reg_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;
  logic [REG_W-1:0]  hold_reg_q;
  logic [DATA_W-1:0] hold_data_q;

  logic              ld_ready_s, ld_acc_s, ld_drop_s;
  logic              deq_s, enq_s, bypass_s;
  logic              head_live_s, q_hit_s;
  logic [REG_W-1:0]  head_reg_s;
  logic [DATA_W-1:0] head_data_s;

  wb_defer_fifo #(.REG_W(REG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_i      (enq_s),
    .enq_reg_i  (bus.ld_reg),
    .enq_data_i (bus.ld_data),
    .deq_i      (deq_s),
    .kill_i     (bus.wb_valid),
    .kill_reg_i (bus.wb_reg),
    .q_reg_i    (bus.q_reg),
    .head_live_o(head_live_s),
    .head_reg_o (head_reg_s),
    .head_data_o(head_data_s),
    .q_hit_o    (q_hit_s)
  );

  // rdy_en_q keeps ld_ready low through reset and the release cycle's edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    case (state_q)
      ST_EMPTY: state_d = enq_s ? ST_ONE : ST_EMPTY;
      ST_ONE: begin
        if (enq_s && !deq_s) begin
          state_d = ST_FULL;
        end else if (deq_s && !enq_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: state_d = deq_s ? ST_ONE : ST_FULL;
      default: state_d = ST_EMPTY;
    endcase
  end

  // A dead head still costs one drain cycle, during which nothing else writes
  always_comb begin
    ld_ready_s = rdy_en_q && (state_q != ST_FULL);
    ld_acc_s   = bus.ld_valid && ld_ready_s;
    ld_drop_s  = ld_acc_s && bus.wb_valid && (bus.ld_reg == bus.wb_reg);
    deq_s      = 1'b0;
    bypass_s   = 1'b0;
    rf_we_d    = 1'b0;
    rf_reg_d   = rf_reg_q;
    rf_data_d  = rf_data_q;
    if (bus.wb_valid) begin
      rf_we_d   = 1'b1;
      rf_reg_d  = bus.wb_reg;
      rf_data_d = bus.wb_data;
    end else if (state_q != ST_EMPTY) begin
      deq_s = 1'b1;
      if (head_live_s) begin
        rf_we_d   = 1'b1;
        rf_reg_d  = head_reg_s;
        rf_data_d = head_data_s;
      end else begin
        rf_we_d = 1'b0;
      end
    end else if (ld_acc_s) begin
      bypass_s  = 1'b1;
      rf_we_d   = 1'b1;
      rf_reg_d  = bus.ld_reg;
      rf_data_d = bus.ld_data;
    end else begin
      rf_we_d = 1'b0;
    end
    enq_s   = ld_acc_s && !bypass_s && !ld_drop_s;
    stall_d = bus.ld_valid && !ld_ready_s;
    err_d   = err_q || (stall_q && (!bus.ld_valid || (bus.ld_reg != hold_reg_q)
                                    || (bus.ld_data != hold_data_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q     <= 1'b0;
      rf_reg_q    <= '0;
      rf_data_q   <= '0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
      hold_reg_q  <= '0;
      hold_data_q <= '0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_reg_q    <= rf_reg_d;
      rf_data_q   <= rf_data_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
      hold_reg_q  <= bus.ld_reg;
      hold_data_q <= bus.ld_data;
    end
  end

  assign bus.ld_ready = ld_ready_s;
  assign bus.q_hit    = q_hit_s;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_reg   = rf_reg_q;
  assign bus.rf_data  = rf_data_q;
  assign bus.err      = err_q;

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: table of cycle stimuli with
// hand-computed port results, plus hand-written reset sequences.
module tb_wb_port_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  wb_port_arbiter_if #(.REG_W(3), .DATA_W(16)) bus ();

  wb_port_arbiter #(.REG_W(3), .DATA_W(16), .DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        lv;
    logic [2:0]  lr;
    logic [15:0] ld;
    logic [2:0]  qr;
    logic        e_rdy;
    logic        e_hit;
    logic        e_we;
    logic [2:0]  e_reg;
    logic [15:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t tv [30];

  function automatic vec_t mk(input logic wv, input logic [2:0] wr, input logic [15:0] wd,
                              input logic lv, input logic [2:0] lr, input logic [15:0] ld,
                              input logic [2:0] qr, input logic e_rdy, input logic e_hit,
                              input logic e_we, input logic [2:0] e_reg,
                              input logic [15:0] e_data, input logic e_err);
    vec_t v;
    v.wv = wv; v.wr = wr; v.wd = wd; v.lv = lv; v.lr = lr; v.ld = ld; v.qr = qr;
    v.e_rdy = e_rdy; v.e_hit = e_hit; v.e_we = e_we; v.e_reg = e_reg;
    v.e_data = e_data; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      miscompares++;
    end
  endtask

  task automatic drive_idle(input logic [2:0] qr);
    bus.wb_valid = 1'b0; bus.wb_reg = 3'd0; bus.wb_data = 16'h0000;
    bus.ld_valid = 1'b0; bus.ld_reg = 3'd0; bus.ld_data = 16'h0000;
    bus.q_reg = qr;
  endtask

  // Entered and left on a falling edge
  task automatic apply(input vec_t v, input int idx);
    bus.wb_valid = v.wv; bus.wb_reg = v.wr; bus.wb_data = v.wd;
    bus.ld_valid = v.lv; bus.ld_reg = v.lr; bus.ld_data = v.ld;
    bus.q_reg = v.qr;
    #1;
    vectors++;
    chk($sformatf("v%0d ld_ready", idx), {31'd0, bus.ld_ready}, {31'd0, v.e_rdy});
    chk($sformatf("v%0d q_hit", idx), {31'd0, bus.q_hit}, {31'd0, v.e_hit});
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d rf_we", idx), {31'd0, bus.rf_we}, {31'd0, v.e_we});
    chk($sformatf("v%0d rf_reg", idx), {29'd0, bus.rf_reg}, {29'd0, v.e_reg});
    chk($sformatf("v%0d rf_data", idx), {16'd0, bus.rf_data}, {16'd0, v.e_data});
    chk($sformatf("v%0d err", idx), {31'd0, bus.err}, {31'd0, v.e_err});
  endtask

  task automatic chk_zero_outs(input string name);
    vectors++;
    chk({name, " rf_we"}, {31'd0, bus.rf_we}, 32'd0);
    chk({name, " rf_reg"}, {29'd0, bus.rf_reg}, 32'd0);
    chk({name, " rf_data"}, {16'd0, bus.rf_data}, 32'd0);
    chk({name, " err"}, {31'd0, bus.err}, 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    //            wv  wr    wd        lv  lr    ld        qr    rdy  hit  we   reg   data      err
    tv[0]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    tv[1]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hBEEF, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0);
    tv[2]  = mk(1'b1, 3'd1, 16'h0001, 1'b1, 3'd2, 16'h0002, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0001, 1'b0);
    tv[3]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 3'd2, 16'h0002, 1'b0);
    tv[4]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0002, 1'b0);
    tv[5]  = mk(1'b1, 3'd1, 16'h0011, 1'b1, 3'd4, 16'h0044, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0011, 1'b0);
    tv[6]  = mk(1'b1, 3'd1, 16'h0012, 1'b1, 3'd6, 16'h0066, 3'd4, 1'b1, 1'b1, 1'b1, 3'd1, 16'h0012, 1'b0);
    tv[7]  = mk(1'b1, 3'd1, 16'h0013, 1'b1, 3'd7, 16'h0077, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0013, 1'b0);
    tv[8]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h0077, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0044, 1'b0);
    tv[9]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h0077, 3'd0, 1'b1, 1'b0, 1'b1, 3'd6, 16'h0066, 1'b0);
    tv[10] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b1, 3'd7, 16'h0077, 1'b0);
    tv[11] = mk(1'b1, 3'd1, 16'h0021, 1'b1, 3'd5, 16'h0050, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0021, 1'b0);
    tv[12] = mk(1'b1, 3'd5, 16'h0055, 1'b0, 3'd0, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 16'h0055, 1'b0);
    tv[13] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0055, 1'b0);
    tv[14] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0055, 1'b0);
    tv[15] = mk(1'b1, 3'd3, 16'h0033, 1'b1, 3'd3, 16'h0099, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0033, 1'b0);
    tv[16] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0033, 1'b0);
    tv[17] = mk(1'b1, 3'd1, 16'h0041, 1'b1, 3'd2, 16'h0042, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0041, 1'b0);
    tv[18] = mk(1'b1, 3'd2, 16'h0043, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0043, 1'b0);
    tv[19] = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0046, 3'd0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0043, 1'b0);
    tv[20] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b1, 3'd6, 16'h0046, 1'b0);
    tv[21] = mk(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0101, 1'b0);
    tv[22] = mk(1'b1, 3'd1, 16'h0102, 1'b1, 3'd3, 16'h0303, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0102, 1'b0);
    tv[23] = mk(1'b1, 3'd1, 16'h0111, 1'b1, 3'd2, 16'h0222, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0111, 1'b0);
    tv[24] = mk(1'b1, 3'd1, 16'h0112, 1'b1, 3'd3, 16'h0333, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0112, 1'b0);
    tv[25] = mk(1'b1, 3'd1, 16'h0113, 1'b1, 3'd4, 16'h0AAA, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0113, 1'b0);
    tv[26] = mk(1'b1, 3'd1, 16'h0114, 1'b1, 3'd4, 16'h0BBB, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0114, 1'b1);
    tv[27] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0222, 1'b1);
    tv[28] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0333, 1'b1);
    tv[29] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0333, 1'b1);

    rst_n = 1'b0;
    drive_idle(3'd0);
    @(negedge clk);
    @(negedge clk);
    chk_zero_outs("por");
    chk("por ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    vectors++;
    chk("release ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      apply(tv[i], i);
    end

    // Buffer is FULL here: asynchronous reset mid-cycle, then watch for stray writes
    drive_idle(3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("rst_full");
    chk("rst_full ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("rst_full q_hit", {31'd0, bus.q_hit}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_zero_outs($sformatf("drain%0d", i));
      chk($sformatf("drain%0d q_hit", i), {31'd0, bus.q_hit}, 32'd0);
      chk($sformatf("drain%0d ld_ready", i), {31'd0, bus.ld_ready}, 32'd1);
    end

    for (int i = 23; i < 30; i++) begin
      apply(tv[i], i);
    end

    rst_n = 1'b0;
    #1;
    chk_zero_outs("err_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outs("err_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_wb_port_arbiter

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameters SHALL be: REG_W, default 3, register index width; DATA_W, default 16, write data width; DEPTH, fixed 2, deferred-write buffer entries.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 wb_valid  in  1  pipeline writeback request; never back-pressured.
REQ-005 wb_reg  in  REG_W  pipeline destination register.
REQ-006 wb_data  in  DATA_W  pipeline writeback data, from the link/load/ALU select.
REQ-007 ld_valid  in  1  late-return (multicycle load) write request.
REQ-008 ld_ready  out  1  late-return accept; a handshake occurs when ld_valid and ld_ready are both high.
REQ-009 ld_reg, ld_data  in  REG_W, DATA_W  late-return destination register and data.
REQ-010 q_reg  in  REG_W  hazard-query register index.
REQ-011 q_hit  out  1  a live buffered write targets q_reg (combinational).
REQ-012 rf_we, rf_reg, rf_data  out  1, REG_W, DATA_W  registered register-file write port.
REQ-013 err  out  1  sticky protocol error.

Function
REQ-014 The FSM SHALL have three states (EMPTY, ONE, FULL) equal to the buffer occupancy.
REQ-015 ld_ready SHALL be high in EMPTY and ONE and low in FULL, with no same-cycle full-to-ready bypass.
REQ-016 Each cycle exactly one source SHALL drive the port, in priority order: wb_valid first; otherwise a live buffer head; otherwise an accepted late-return (bypass).
REQ-017 The port outputs SHALL register the selected write with 1-cycle latency; with no source selected, rf_we SHALL be 0 and rf_reg/rf_data SHALL hold.
REQ-018 An accepted late-return that is not bypassed SHALL enqueue at the tail, in the same cycle as any dequeue.
REQ-019 Buffer order SHALL be strict FIFO with a 1-bit wrapping read/write pointer.
REQ-020 A live buffered entry SHALL be killed (its live bit cleared) when wb_valid is high and wb_reg equals its register, because the newer pipeline value wins.
REQ-021 An accepted late-return whose ld_reg equals wb_reg in a cycle with wb_valid high SHALL be discarded and SHALL NOT be enqueued.
REQ-022 When no wb_valid is present, a killed head SHALL dequeue in one cycle with no write, and the next source SHALL NOT be selected that cycle.
REQ-023 q_hit SHALL consider only live entries, and SHALL NOT reflect enqueues or kills occurring in the current cycle.
REQ-024 err SHALL set when ld_valid drops, or ld_reg/ld_data change, while ld_valid is high and ld_ready is low.
REQ-025 err SHALL clear only on reset.

Reset
REQ-026 Asserting rst_n low SHALL immediately force: state EMPTY, pointers 0, all live bits 0, rf_we 0, rf_reg 0, rf_data 0, err 0.
REQ-027 During reset, ld_ready SHALL be 0; after deassertion, ld_ready SHALL be 1 from the first clock edge.
REQ-028 Reset mid-drain SHALL discard all buffered writes without any write-port activity.

Structure
REQ-029 A shared header SHALL hold the state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the REG_W/DATA_W defaults, so the decode and hazard units can use them.
REQ-030 The 2-entry buffer SHALL be one sub-module, wb_defer_fifo, containing the storage, live bits, kill compare and q_hit compare.
REQ-031 The arbiter top SHALL hold the FSM, priority mux, output register and err logic.

Verification
REQ-032 Bypass: idle; ld_valid with reg 3, data 16'hBEEF -> next cycle rf_we=1, rf_reg=3, rf_data=16'hBEEF.
REQ-033 Conflict: wb_valid with reg 1, data 16'h0001 and ld with reg 2, data 16'h0002 in the same cycle -> rf_reg=1, then rf_reg=2 one cycle later.
REQ-034 Full: wb_valid held for 3 cycles while ld_valid is high -> ld_ready falls after 2 accepts; after wb_valid drops, exactly 2 buffered writes emerge in FIFO order.
REQ-035 Kill: buffered entry reg 5 (q_reg=5 gives q_hit=1), then wb_valid with reg 5, data 16'h0055 -> q_hit=0 next cycle; the only write to reg 5 carries 16'h0055.
REQ-036 Reset: rst_n pulsed low while FULL -> all outputs zero asynchronously, no writes after release, err=0.
REQ-037 Protocol: ld_data changed while ld_valid is high and ld_ready is low -> err=1 and stays 1 until reset.
